call_stack: RTL and testbench

CALL_STACK -- requirements
Module: call_stack

---
 rtl/call_stack_mem.sv | 25 ++
 rtl/call_stack.sv | 99 +++++++++
 tb/tb_call_stack.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/call_stack_mem.sv
// Return-address storage: DEPTH x NBITS, one synchronous write port and one
// asynchronous read port. Contents are not reset; the caller masks stale data.
module call_stack_mem #(
  parameter int NBITS = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [NBITS-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [NBITS-1:0] rdata
);

  logic [NBITS-1:0] mem [DEPTH];

  // Write the selected entry on the rising edge
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/call_stack.sv
// Hardware call stack for return addresses. Supports call (push), return
// (pop) and tail-call (push+pop) with zero-cycle return latency: dout shows
// the top entry combinationally so the PC can load it in the pop cycle.
module call_stack #(
  parameter int NBITS = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clr,
  input  logic [NBITS-1:0]         din,
  output logic [NBITS-1:0]         dout,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic                     empty,
  output logic                     full,
  output logic                     ovf,
  output logic                     udf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  logic [AW:0]      cnt_nxt;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    top;
  logic [NBITS-1:0] rdata;
  logic             ovf_set;
  logic             udf_set;

  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_MAX);

  // Index of the current top entry; only meaningful when not empty.
  assign top  = AW'(cnt - 1'b1);
  assign dout = empty ? '0 : rdata;

  // Decode push/pop into the write strobe, write slot, next count and flag sets
  always_comb begin
    cnt_nxt = cnt;
    we      = 1'b0;
    waddr   = '0;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    unique case ({push, pop})
      2'b10: begin
        if (full) begin
          ovf_set = 1'b1;
        end else begin
          we      = 1'b1;
          waddr   = AW'(cnt);
          cnt_nxt = cnt + 1'b1;
        end
      end
      2'b01: begin
        if (empty) udf_set = 1'b1;
        else       cnt_nxt = cnt - 1'b1;
      end
      2'b11: begin
        // Tail-call replaces the top in place; on an empty stack the pop
        // underflows but the push still lands in slot 0.
        we = 1'b1;
        if (empty) begin
          udf_set = 1'b1;
          waddr   = '0;
          cnt_nxt = (AW+1)'(1);
        end else begin
          waddr   = top;
        end
      end
      default: ;
    endcase
  end

  // Count and sticky flags; a new violation wins over clr in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      ovf <= ovf_set | (ovf & ~clr);
      udf <= udf_set | (udf & ~clr);
    end
  end

  call_stack_mem #(.NBITS(NBITS), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (din),
    .raddr (top),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_call_stack.sv
// Self-checking bench for call_stack: directed vector table, hand-written
// corner sequences (overflow, async reset) and random traffic against a
// queue-based reference model.
module tb_call_stack;

  localparam int NBITS = 8;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             push = 1'b0, pop = 1'b0, clr = 1'b0;
  logic [NBITS-1:0] din = '0;
  logic [NBITS-1:0] dout;
  logic [3:0]       cnt;
  logic             empty, full, ovf, udf;

  int checks = 0;
  int errors = 0;

  call_stack #(.NBITS(NBITS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .clr(clr), .din(din),
    .dout(dout), .cnt(cnt), .empty(empty), .full(full), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         p, q, c;
    logic [7:0] d;
    logic [7:0] edout;   // dout before the edge (in the operation cycle)
    int         ecnt;    // state after the edge
    bit         eovf, eudf;
  } vec_t;

  vec_t vecs[$];

  // reference model state
  int         mq[$];
  bit         movf, mudf;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one operation at the falling edge; return 1ns after the rising edge.
  task automatic drive(input bit p, input bit q, input bit c, input logic [7:0] d,
                       output logic [7:0] pre_dout);
    @(negedge clk);
    push = p; pop = q; clr = c; din = d;
    #1 pre_dout = dout;
    @(posedge clk);
    #1;
    push = 0; pop = 0; clr = 0;
  endtask

  task automatic chk_state(input string tag, input int ecnt, input bit eo, input bit eu);
    chk({tag, ".cnt"},   int'(cnt),   ecnt);
    chk({tag, ".empty"}, int'(empty), int'(ecnt == 0));
    chk({tag, ".full"},  int'(full),  int'(ecnt == DEPTH));
    chk({tag, ".ovf"},   int'(ovf),   int'(eo));
    chk({tag, ".udf"},   int'(udf),   int'(eu));
  endtask

  // Reference step computed from the stack rules on a plain queue.
  task automatic model_step(input bit p, input bit q, input bit c, input int d);
    bit os = 0, us = 0;
    if (p && !q) begin
      if (mq.size() < DEPTH) mq.push_back(d); else os = 1;
    end else if (q && !p) begin
      if (mq.size() > 0) void'(mq.pop_back()); else us = 1;
    end else if (p && q) begin
      if (mq.size() > 0) mq[mq.size()-1] = d;
      else begin us = 1; mq.push_back(d); end
    end
    movf = os | (movf & !c);
    mudf = us | (mudf & !c);
  endtask

  initial begin
    logic [7:0] pd;

    vecs.push_back('{0,0,0,8'h00, 8'h00, 0, 0,0});
    vecs.push_back('{1,0,0,8'h11, 8'h00, 1, 0,0});
    vecs.push_back('{1,0,0,8'h22, 8'h11, 2, 0,0});
    vecs.push_back('{1,0,0,8'h33, 8'h22, 3, 0,0});
    vecs.push_back('{0,1,0,8'h00, 8'h33, 2, 0,0});
    vecs.push_back('{0,1,0,8'h00, 8'h22, 1, 0,0});
    vecs.push_back('{0,1,0,8'h00, 8'h11, 0, 0,0});
    vecs.push_back('{0,1,0,8'h00, 8'h00, 0, 0,1});
    vecs.push_back('{0,0,0,8'h00, 8'h00, 0, 0,1});
    vecs.push_back('{0,0,1,8'h00, 8'h00, 0, 0,0});
    vecs.push_back('{0,1,1,8'h00, 8'h00, 0, 0,1});
    vecs.push_back('{0,0,1,8'h00, 8'h00, 0, 0,0});
    vecs.push_back('{1,0,0,8'hA0, 8'h00, 1, 0,0});
    vecs.push_back('{1,0,0,8'hB0, 8'hA0, 2, 0,0});
    vecs.push_back('{1,1,0,8'hC0, 8'hB0, 2, 0,0});
    vecs.push_back('{0,1,0,8'h00, 8'hC0, 1, 0,0});
    vecs.push_back('{0,1,0,8'h00, 8'hA0, 0, 0,0});
    vecs.push_back('{1,1,0,8'h5A, 8'h00, 1, 0,1});
    vecs.push_back('{0,1,0,8'h00, 8'h5A, 0, 0,1});
    vecs.push_back('{0,0,1,8'h00, 8'h00, 0, 0,0});

    // reset state
    #12;
    chk("rst.dout", int'(dout), 0);
    chk_state("rst", 0, 0, 0);
    @(negedge clk); rst = 0;

    // directed table
    foreach (vecs[i]) begin
      drive(vecs[i].p, vecs[i].q, vecs[i].c, vecs[i].d, pd);
      chk($sformatf("vec%0d.dout", i), int'(pd), int'(vecs[i].edout));
      chk_state($sformatf("vec%0d", i), vecs[i].ecnt, vecs[i].eovf, vecs[i].eudf);
    end

    // fill to full, then overflow
    for (int k = 1; k <= 8; k++) begin
      drive(1, 0, 0, 8'(k), pd);
      chk($sformatf("fill%0d.cnt", k), int'(cnt), k);
    end
    drive(1, 0, 0, 8'h09, pd);
    chk("ovf.dout_pre", int'(pd), 8'h08);
    chk_state("ovf", 8, 1, 0);
    chk("ovf.dout", int'(dout), 8'h08);
    for (int k = 8; k >= 1; k--) begin
      drive(0, 1, 0, 8'h00, pd);
      chk($sformatf("drain%0d.dout", k), int'(pd), k);
    end
    chk_state("drained", 0, 1, 0);
    drive(0, 0, 1, 8'h00, pd);
    chk_state("ovf_clr", 0, 0, 0);

    // asynchronous reset between edges
    drive(1, 0, 0, 8'h44, pd);
    drive(1, 0, 0, 8'h55, pd);
    chk("pre_arst.cnt", int'(cnt), 2);
    #1 rst = 1;
    #1;
    chk("arst.cnt",   int'(cnt),   0);
    chk("arst.empty", int'(empty), 1);
    chk("arst.dout",  int'(dout),  0);
    #1 rst = 0;
    drive(1, 0, 0, 8'h66, pd);
    chk("post_arst.dout", int'(dout), 8'h66);
    chk("post_arst.cnt",  int'(cnt),  1);

    // random traffic against the model
    mq.delete(); movf = 0; mudf = 0;
    model_step(1, 0, 0, 8'h66);
    for (int n = 0; n < 600; n++) begin
      bit p, q, c;
      logic [7:0] d;
      int exp_pre;
      int phase = (n / 50) % 3;   // bias toward filling, draining, mixed
      p = ($urandom_range(99) < (phase == 0 ? 70 : phase == 1 ? 25 : 50));
      q = ($urandom_range(99) < (phase == 0 ? 25 : phase == 1 ? 70 : 50));
      c = ($urandom_range(99) < 8);
      d = 8'($urandom);
      exp_pre = (mq.size() > 0) ? mq[mq.size()-1] : 0;
      drive(p, q, c, d, pd);
      model_step(p, q, c, int'(d));
      chk($sformatf("rnd%0d.dout", n), int'(pd), exp_pre);
      chk_state($sformatf("rnd%0d", n), mq.size(), movf, mudf);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
